approx_mult_err_monitor: RTL and testbench

//  Downstream accuracy monitor for the 8x8 approximate multipliers.
//  - Consumes each operand pair (a, b) with the approximate product r from the multiplier under test.
//  - Recomputes the exact product and accumulates error metrics over windows of N = 2**WIN_LOG2 samples.
//  - Metrics per window: sum of error distances (gives MED), maximum error distance, erroneous-result count (gives ER).
//  - Reports each window through a valid/ready handshake.

---
 rtl/approx_mult_pkg.sv | 20 ++
 rtl/err_dist_stage.sv | 79 +++++++
 rtl/approx_mult_err_monitor.sv | 151 +++++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate-multiplier accuracy monitor.
package approx_mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } mon_state_t;

    function automatic logic [PROD_W-1:0] abs_diff16(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y
    );
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/err_dist_stage.sv
// Two-stage pipe: capture (a, b, r), then exact product, |r - a*b| and error flag.
// Optional ERR_BIAS_EN also carries the signed difference r - a*b.
module err_dist_stage
    import approx_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              take_i,
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    input  logic [PROD_W-1:0] r_i,
    output logic              vld_o,
    output logic [PROD_W-1:0] dist_o,
    output logic              neq_o
`ifdef ERR_BIAS_EN
   ,output logic signed [PROD_W:0] diff_o
`endif
);

    logic              s1_vld_q;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [PROD_W-1:0] r_q;

    logic              s2_vld_q;
    logic [PROD_W-1:0] dist_q;
    logic              neq_q;

    logic [PROD_W-1:0] exact_d;
    logic [PROD_W-1:0] dist_d;

    assign exact_d = PROD_W'(a_q) * PROD_W'(b_q);
    assign dist_d  = abs_diff16(r_q, exact_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            s2_vld_q <= 1'b0;
            dist_q   <= '0;
            neq_q    <= 1'b0;
        end else begin
            // take_i is already gated by clear in the parent
            s1_vld_q <= take_i;
            if (take_i) begin
                a_q <= a_i;
                b_q <= b_i;
                r_q <= r_i;
            end
            s2_vld_q <= s1_vld_q && !clear;
            if (s1_vld_q) begin
                dist_q <= dist_d;
                neq_q  <= (dist_d != '0);
            end
        end
    end

`ifdef ERR_BIAS_EN
    logic signed [PROD_W:0] diff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= '0;
        end else if (s1_vld_q) begin
            diff_q <= $signed({1'b0, r_q}) - $signed({1'b0, exact_d});
        end
    end

    assign diff_o = diff_q;
`endif

    assign vld_o  = s2_vld_q;
    assign dist_o = dist_q;
    assign neq_o  = neq_q;

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Windowed error monitor (sum / max / count of |r - a*b|) for 8x8 approximate multipliers.
// ERR_BIAS_EN adds a signed bias accumulator and the err_bias output.
module approx_mult_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int WIN_LOG2 = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              a,
    input  logic [OP_W-1:0]              b,
    input  logic [PROD_W-1:0]            r,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PROD_W+WIN_LOG2-1:0]   err_sum,
    output logic [PROD_W-1:0]            err_max,
    output logic [WIN_LOG2:0]            err_cnt
`ifdef ERR_BIAS_EN
   ,output logic signed [PROD_W+WIN_LOG2:0] err_bias
`endif
);

    localparam int SUM_W = PROD_W + WIN_LOG2;
    localparam int CNT_W = WIN_LOG2 + 1;

    mon_state_t          state_q;
    logic [WIN_LOG2-1:0] smp_cnt_q;
    logic                drain_q;
    logic                out_valid_q;

    logic [SUM_W-1:0]    sum_q;
    logic [PROD_W-1:0]   max_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                take;
    logic                out_hs;
    logic                s2_vld;
    logic [PROD_W-1:0]   s2_dist;
    logic                s2_neq;

    assign in_ready = (state_q == ACCUM);
    assign take     = in_valid && in_ready && !clear;
    assign out_hs   = out_valid_q && out_ready;

`ifdef ERR_BIAS_EN
    logic signed [PROD_W:0]       s2_diff;
    logic signed [SUM_W:0]        bias_q;
`endif

    err_dist_stage u_dist (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .take_i (take),
        .a_i    (a),
        .b_i    (b),
        .r_i    (r),
        .vld_o  (s2_vld),
        .dist_o (s2_dist),
        .neq_o  (s2_neq)
`ifdef ERR_BIAS_EN
       ,.diff_o (s2_diff)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            smp_cnt_q   <= '0;
            drain_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            state_q     <= ACCUM;
            smp_cnt_q   <= '0;
            drain_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (take) begin
                        smp_cnt_q <= smp_cnt_q + 1'b1;
                        if (smp_cnt_q == '1) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                // two idle cycles let the last sample reach the accumulators
                DRAIN: begin
                    if (drain_q) begin
                        drain_q     <= 1'b0;
                        state_q     <= REPORT;
                        out_valid_q <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state_q     <= ACCUM;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
        end else if (clear || out_hs) begin
            sum_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
        end else if (s2_vld) begin
            sum_q <= sum_q + SUM_W'(s2_dist);
            cnt_q <= cnt_q + CNT_W'(s2_neq);
            if (s2_dist > max_q) begin
                max_q <= s2_dist;
            end
        end
    end

`ifdef ERR_BIAS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q <= '0;
        end else if (clear || out_hs) begin
            bias_q <= '0;
        end else if (s2_vld) begin
            bias_q <= bias_q + (SUM_W+1)'(s2_diff);
        end
    end

    assign err_bias = bias_q;
`endif

    assign out_valid = out_valid_q;
    assign err_sum   = sum_q;
    assign err_max   = max_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor with a 4-sample window.
module tb_approx_mult_err_monitor;

    localparam int WL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    a = '0;
    logic [7:0]    b = '0;
    logic [15:0]   r = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [17:0]   err_sum;
    logic [15:0]   err_max;
    logic [2:0]    err_cnt;
`ifdef ERR_BIAS_EN
    logic signed [18:0] err_bias;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic mon_en = 1'b0;
    int   hs_cnt = 0;
    int   low_cnt = 0;
    int   ov_cnt = 0;

    approx_mult_err_monitor #(.WIN_LOG2(WL)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sum   (err_sum),
        .err_max   (err_max),
        .err_cnt   (err_cnt)
`ifdef ERR_BIAS_EN
       ,.err_bias  (err_bias)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!in_ready) low_cnt++;
            if (out_valid) ov_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                chk("b2b_sum", 64'(err_sum), 64'd4);
                chk("b2b_cnt", 64'(err_cnt), 64'd4);
            end
        end
    end

    // returns at posedge+1 after the accepting edge
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] rv);
        int t = 0;
        in_valid = 1'b1; a = av; b = bv; r = rv;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 64'(t), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_mixed();
        send(8'd15, 8'd15, 16'd224);
        send(8'd10, 8'd10, 16'd100);
        send(8'd255, 8'd255, 16'd65000);
        send(8'd3, 8'd4, 16'd12);
    endtask

    // ends on the negedge where out_valid should have just risen
    task automatic expect_report(input string tag, input int s, input int m, input int c);
        @(negedge clk);
        chk({tag, "_ov_t1"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy_t1"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        chk({tag, "_ov_t2"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_ov"}, 64'(out_valid), 64'd1);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd0);
        chk({tag, "_sum"}, 64'(err_sum), 64'(s));
        chk({tag, "_max"}, 64'(err_max), 64'(m));
        chk({tag, "_cnt"}, 64'(err_cnt), 64'(c));
    endtask

    task automatic take_report(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_hs_rdy"}, 64'(in_ready), 64'd1);
        chk({tag, "_hs_ov"}, 64'(out_valid), 64'd0);
        chk({tag, "_hs_sum"}, 64'(err_sum), 64'd0);
    endtask

    initial begin
        logic [17:0] held_sum;

        #12;
        chk("rst_rdy", 64'(in_ready), 64'd1);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(err_sum), 64'd0);
        chk("rst_max", 64'(err_max), 64'd0);
        chk("rst_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) send(8'd15, 8'd15, 16'd225);
        expect_report("exact", 0, 0, 0);
        take_report("exact");

        @(posedge clk); #1;
        send_mixed();
        expect_report("mixed", 26, 25, 2);
`ifdef ERR_BIAS_EN
        chk("mixed_bias", 64'(err_bias), -64'sd26);
`endif
        take_report("mixed");

        // back-pressure
        @(posedge clk); #1;
        send_mixed();
        expect_report("bp", 26, 25, 2);
        held_sum = err_sum;
        repeat (20) @(negedge clk);
        chk("bp_rdy_held", 64'(in_ready), 64'd0);
        chk("bp_ov_held", 64'(out_valid), 64'd1);
        chk("bp_sum_held", 64'(err_sum), 64'(held_sum));
        chk("bp_max_held", 64'(err_max), 64'd25);
        take_report("bp");
        @(posedge clk); #1;
        send(8'd2, 8'd3, 16'd7);
        for (int i = 0; i < 3; i++) send(8'd1, 8'd1, 16'd1);
        expect_report("bp_next", 1, 1, 1);
        take_report("bp_next");

        // back-to-back, every sample off by one
        @(posedge clk); #1;
        out_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 12; i++) send(8'd2, 8'd3, 16'd7);
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        out_ready = 1'b0;
        chk("b2b_reports", 64'(hs_cnt), 64'd3);
        chk("b2b_rdy_low", 64'(low_cnt), 64'd9);

        // clear mid-window; sample presented with clear must be dropped
        @(posedge clk); #1;
        send(8'd15, 8'd15, 16'd224);
        send(8'd255, 8'd255, 16'd65000);
        clear = 1'b1; in_valid = 1'b1; a = 8'd15; b = 8'd15; r = 16'd200;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clr_sum", 64'(err_sum), 64'd0);
        chk("clr_rdy", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) send(8'd7, 8'd9, 16'd63);
        expect_report("clr", 0, 0, 0);

        // clear coinciding with the output handshake
        out_ready = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
        send_mixed();
        expect_report("clrhs", 26, 25, 2);
        out_ready = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; clear = 1'b0;
        @(negedge clk);
        chk("clrhs_ov", 64'(out_valid), 64'd0);
        chk("clrhs_rdy", 64'(in_ready), 64'd1);
        chk("clrhs_max", 64'(err_max), 64'd0);

        // async reset while draining
        @(posedge clk); #1;
        send_mixed();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rdy", 64'(in_ready), 64'd1);
        chk("arst_ov", 64'(out_valid), 64'd0);
        chk("arst_sum", 64'(err_sum), 64'd0);
        chk("arst_max", 64'(err_max), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ov_cnt = 0;
        mon_en = 1'b1;
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        chk("arst_no_stale", 64'(ov_cnt), 64'd0);
        chk("arst_cnt", 64'(err_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
